// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - shared condition codes, flag indices and flag-write selects
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [1:0] flagw_t;

  localparam flagw_t FLAGW_NZ = 2'b10;
  localparam flagw_t FLAGW_CV = 2'b01;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational condition-field evaluation against {N,Z,C,V}
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      EQ: cond_ex = z;
      NE: cond_ex = ~z;
      CS: cond_ex = c;
      CC: cond_ex = ~c;
      MI: cond_ex = n;
      PL: cond_ex = ~n;
      VS: cond_ex = v;
      VC: cond_ex = ~v;
      HI: cond_ex = c & ~z;
      LS: cond_ex = ~c | z;
      GE: cond_ex = (n == v);
      LT: cond_ex = (n != v);
      GT: cond_ex = ~z & (n == v);
      LE: cond_ex = z | (n != v);
      AL: cond_ex = 1'b1;
      NV: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - flag register, condition gating and execute-to-memory control register
module cond_logic
  import cond_pkg::*;
#(
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic [3:0]        Cond,
  input  logic [FLAG_W-1:0] ALUFlags,
  input  logic [1:0]        FlagW,
  input  logic              PCS,
  input  logic              RegW,
  input  logic              MemW,
  input  logic              NoWrite,
  output logic              CondEx,
  output logic              PCSrc,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              PCSrcM,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [FLAG_W-1:0] Flags
);

  logic [1:0] flags_nz;
  logic [1:0] flags_cv;
  logic       gate;
  logic       flag_upd;

  assign Flags = {flags_nz, flags_cv};

  // Condition is judged on the registered flags only, so an instruction never sees its own result.
  cond_check u_cond_check (
    .cond    (Cond),
    .flags   (Flags),
    .cond_ex (CondEx)
  );

  assign gate     = CondEx & ~flush;
  assign PCSrc    = PCS & gate;
  assign RegWrite = RegW & ~NoWrite & gate;
  assign MemWrite = MemW & gate;
  assign flag_upd = en & gate;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_nz <= 2'b00;
    end else if (flag_upd && (FlagW & FLAGW_NZ) != 2'b00) begin
      flags_nz <= {ALUFlags[FLAG_N], ALUFlags[FLAG_Z]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_cv <= 2'b00;
    end else if (flag_upd && (FlagW & FLAGW_CV) != 2'b00) begin
      flags_cv <= {ALUFlags[FLAG_C], ALUFlags[FLAG_V]};
    end
  end

  // Flush loads a bubble even while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PCSrcM    <= 1'b0;
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
    end else if (flush) begin
      PCSrcM    <= 1'b0;
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
    end else if (en) begin
      PCSrcM    <= PCSrc;
      RegWriteM <= RegWrite;
      MemWriteM <= MemWrite;
    end
  end

endmodule

// File: doc/cond_logic.md
# cond_logic

Conditional-execution unit consuming the NZCV flags produced by the ALU with flags. It holds the architectural flag register and evaluates the 4-bit condition field against it. It gates the write and branch enables of the current instruction and registers the gated controls into the next pipeline stage. It sits in the execute stage, between the decoder's control outputs and the ALU's `ALUFlags` output.

## Interface
- `FLAG_W`, default 4: flag vector width; fixed order {N,Z,C,V}; other values are not supported.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  stage enable; 0 = stall, all state holds.
- `flush`  in  1  bubble insert; squashes the current instruction.
- `Cond`  in  4  instruction condition field.
- `ALUFlags`  in  4  {N,Z,C,V} from the ALU for the current instruction.
- `FlagW`  in  2  bit1 = write N,Z; bit0 = write C,V.
- `PCS`, `RegW`, `MemW`  in  1 each  ungated controls from the decoder.
- `NoWrite`  in  1  compare-type instruction; suppresses the register write.
- `CondEx`  out  1  combinational condition result.
- `PCSrc`, `RegWrite`, `MemWrite`  out  1 each  combinational gated controls.
- `PCSrcM`, `RegWriteM`, `MemWriteM`  out  1 each  registered gated controls.
- `Flags`  out  4  current flag register.

## Operation
- Condition decode, evaluated against `Flags` (the register), never against `ALUFlags`:
  - EQ 0000 Z; NE 0001 ~Z; CS 0010 C; CC 0011 ~C.
  - MI 0100 N; PL 0101 ~N; VS 0110 V; VC 0111 ~V.
  - HI 1000 C&~Z; LS 1001 ~C|Z.
  - GE 1010 N==V; LT 1011 N!=V.
  - GT 1100 ~Z&(N==V); LE 1101 Z|(N!=V).
  - AL 1110 1; NV 1111 0.
- Gated controls:
  - PCSrc = PCS & CondEx & ~flush.
  - RegWrite = RegW & ~NoWrite & CondEx & ~flush.
  - MemWrite = MemW & CondEx & ~flush.
- Flag write at the edge when en & ~flush & CondEx:
  - FlagW[1] loads N,Z from ALUFlags[3:2].
  - FlagW[0] loads C,V from ALUFlags[1:0].
  - Unselected bits hold.
- The ALU's C output is already 0 for XOR/NOT. This block stores C as given and does no opcode qualification.

## Timing
- Reset (rst_n low, asynchronous): Flags = 4'b0000; PCSrcM = RegWriteM = MemWriteM = 0.
  - Combinational outputs follow their inputs during reset.
  - Reset mid-stall clears state regardless of en.
- Latency:
  - Combinational outputs: 0 cycles.
  - Registered controls and flag updates: 1 cycle (visible after the next rising edge).
- Back-to-back: a flag-setting instruction at cycle t is seen by the Cond of the instruction at t+1. An instruction never sees its own flags.
- en = 0, flush = 0: Flags and *M registers hold. Combinational outputs still track inputs.
- flush = 1 (any en):
  - *M registers load 0.
  - Flags hold.
  - Combinational gated outputs are 0.
  - Flush wins over stall.
- Condition false: instruction behaves as a bubble (*M load 0, Flags hold), but it is not a stall.
- No handshake; upstream guarantees inputs are stable while en = 1.

## Structure
- Shared package `cond_pkg`:
  - `cond_t` enum (EQ…NV).
  - Flag index constants FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0.
  - `flagw_t` (2-bit) with FLAGW_NZ = 2'b10 and FLAGW_CV = 2'b01.
- Sub-module `cond_check`: purely combinational (Cond, Flags) -> CondEx.
  - Instantiated once here.
  - Reused by the verification reference model.
- Top level holds the flag register (two independently enabled 2-bit halves), the three-bit *M pipeline register, and the gating.

## Test plan
- Reset: drive rst_n low mid-cycle with Flags = 1111 -> Flags = 0000 and all *M = 0 immediately, without waiting for a clock edge.
- CMP then BEQ: cycle t Cond = 1110, FlagW = 11, ALUFlags = 0100 -> Flags = 0100 at t+1. Cond = 0000, PCS = 1 at t+1 -> PCSrc = 1, PCSrcM = 1 at t+2.
- Partial write:
  - Flags = 1010, FlagW = 10, ALUFlags = 0101 -> Flags = 0110.
  - Then FlagW = 01, ALUFlags = 1001 -> Flags = 0101.
- Condition false: Flags = 0000, Cond = 0000, RegW = MemW = 1, FlagW = 11, ALUFlags = 1111 -> CondEx = 0, RegWrite = MemWrite = 0, Flags stays 0000, *M = 0.
- Stall/flush priority:
  - en = 0 with FlagW = 11: Flags and *M hold over 3 cycles.
  - en = 0 and flush = 1: *M = 0, Flags hold.
- Signed conditions sweep: all 16 Cond × 16 Flags values compared against the `cond_check` model, e.g. Flags = 1000 -> LT = 1, GE = 0, GT = 0, LE = 1; Cond = 1111 -> 0.
